pipeline_hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives enable and flush controls for PC, IF/ID, ID/EX and EX/MEM registers.
- Handles three hazard types:
  - load-use hazards, by inserting a one-cycle bubble into ID/EX;
  - taken-branch/jump redirects resolved in EX, by flushing IF/ID and ID/EX;
  - multi-cycle data-memory waits, by freezing the pipeline, with a watchdog.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 14 +
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 20 ++
 rtl/pipeline_hazard_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int X0_IDX         = 0;
  localparam int TCNT_W         = 8;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
module hazard_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Holds at all-ones rather than wrapping, so long runs never read as small.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, redirect flushes,
// memory-wait freeze with watchdog. Define HAZARD_PERF_CNT_EN to build the perf counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_en,
  output logic                  mem_fault,
  output logic [1:0]            ctrl_state,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  ctrl_state_t       state;
  logic [TCNT_W-1:0] tcnt;
  logic              luse;
  logic              mem_stall;

  assign luse = ex_mem_read && (ex_rd != REG_ADDR_W'(X0_IDX)) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                 (id_uses_rs2 && (id_rs2 == ex_rd)));

  assign mem_stall = mem_req && !mem_ready;

  // Controls are combinational so a hazard is acted on in the cycle it is seen.
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    exmem_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (reset) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (state == RUN) begin
      if (mem_stall) begin
        pc_en = 1'b0;
      end else if (ex_branch_taken) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        exmem_en   = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (luse) begin
        exmem_en   = 1'b1;
        idex_flush = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        exmem_en = 1'b1;
      end
    end
  end

  // tcnt holds the number of stalled cycles in the current memory wait so far.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      tcnt  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            state <= MEM_WAIT;
            tcnt  <= TCNT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state <= RUN;
            tcnt  <= '0;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
            if (({1'b0, tcnt} + 9'd1) >= 9'(MEM_TIMEOUT)) begin
              state <= FAULT;
            end
          end
        end
        FAULT:   state <= FAULT;
        default: state <= RUN;
      endcase
    end
  end

  assign mem_fault  = (state == FAULT);
  assign ctrl_state = state;

`ifdef HAZARD_PERF_CNT_EN
  logic redirect;

  assign redirect = !reset && (state == RUN) && !mem_stall && ex_branch_taken;

  hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!pc_en),
    .count (stall_cnt)
  );

  hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (redirect),
    .count (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
